// File: rtl/pll_apb_cfg_master.sv
// APB requester for the PLL dynamic-configuration port: runs one register read/write
// per fabric command, optionally followed by a PLL reset pulse and a wait for lock.
module pll_apb_cfg_master #(
  parameter int APB_TIMEOUT  = 255,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clkin1,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [4:0]  cmd_addr_i,
  input  logic [15:0] cmd_wdata_i,
  input  logic        cmd_relock_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic        apb_sel_o,
  output logic        apb_en_o,
  output logic        apb_write_o,
  output logic [4:0]  apb_addr_o,
  output logic [15:0] apb_wdata_o,
  input  logic [15:0] apb_rdata_i,
  input  logic        apb_ready_i,
  output logic        pll_rst_o,
  input  logic        lock_i,
  output logic        lock_sync_o,
  output logic        lock_lost_o
);

  localparam int APB_CW  = $clog2(APB_TIMEOUT + 1);
  localparam int RST_CW  = $clog2(RST_CYCLES + 1);
  localparam int LOCK_CW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_APB  = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RST_HOLD,
    S_LOCK_WAIT,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [4:0]           addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic                 relock_q, relock_d;
  logic [15:0]          rdata_q, rdata_d;
  logic [1:0]           err_q, err_d;
  logic [15:0]          rsp_rdata_q, rsp_rdata_d;
  logic [1:0]           rsp_err_q, rsp_err_d;
  logic [APB_CW-1:0]    apb_cnt_q, apb_cnt_d;
  logic [RST_CW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [LOCK_CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic                 pll_rst_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 lock_prev_q;
  logic                 lock_lost_q;
  logic                 lock_sync;

  assign lock_sync = sync_q[SYNC_STAGES-1];

  // NOTE: every always_comb output gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    relock_d    = relock_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    apb_cnt_d   = apb_cnt_q;
    rst_cnt_d   = rst_cnt_q;
    lock_cnt_d  = lock_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d  = S_SETUP;
          write_d  = cmd_write_i;
          addr_d   = cmd_addr_i;
          wdata_d  = cmd_write_i ? cmd_wdata_i : 16'h0000;
          relock_d = cmd_write_i & cmd_relock_i;
          rdata_d  = 16'h0000;
          err_d    = ERR_OK;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        apb_cnt_d = '0;
      end
      S_ACCESS: begin
        if (apb_ready_i) begin
          rdata_d = write_q ? 16'h0000 : apb_rdata_i;
          if (write_q && relock_q) begin
            state_d   = S_RST_HOLD;
            rst_cnt_d = '0;
          end else begin
            state_d = S_RESP;
          end
        end else if (apb_cnt_q >= APB_CW'(APB_TIMEOUT - 1)) begin
          err_d   = ERR_APB;
          state_d = S_RESP;
        end else begin
          apb_cnt_d = apb_cnt_q + 1'b1;
        end
      end
      S_RST_HOLD: begin
        if (rst_cnt_q >= RST_CW'(RST_CYCLES - 1)) begin
          state_d    = S_LOCK_WAIT;
          lock_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_LOCK_WAIT: begin
        if (lock_sync) begin
          state_d = S_RESP;
        end else if (lock_cnt_q >= LOCK_CW'(LOCK_TIMEOUT - 1)) begin
          err_d   = ERR_LOCK;
          state_d = S_RESP;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Response registers only move on RESP entry so they hold between responses.
    if (state_d == S_RESP && state_q != S_RESP) begin
      rsp_rdata_d = rdata_d;
      rsp_err_d   = err_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clkin1) begin
    if (rst) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      relock_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      apb_cnt_q   <= '0;
      rst_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      pll_rst_q   <= 1'b1;
      sync_q      <= '0;
      lock_prev_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      relock_q    <= relock_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      apb_cnt_q   <= apb_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      pll_rst_q   <= (state_d == S_RST_HOLD);
      sync_q      <= {sync_q[SYNC_STAGES-2:0], lock_i};
      lock_prev_q <= lock_sync;
      // Falling lock only reported from IDLE; during relock the drop is expected.
      lock_lost_q <= lock_prev_q & ~lock_sync & (state_q == S_IDLE);
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE) && !rst;
  assign apb_sel_o   = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign apb_en_o    = (state_q == S_ACCESS);
  assign apb_write_o = write_q;
  assign apb_addr_o  = addr_q;
  assign apb_wdata_o = wdata_q;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign pll_rst_o   = pll_rst_q;
  assign lock_sync_o = lock_sync;
  assign lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_pll_apb_cfg_master.sv
// Self-checking bench for pll_apb_cfg_master: directed scenarios followed by random
// commands, each compared with response/latency values computed from the command rules.
module tb_pll_apb_cfg_master;

  localparam int APB_TIMEOUT  = 8;
  localparam int RST_CYCLES   = 16;
  localparam int LOCK_TIMEOUT = 100;
  localparam int SYNC_STAGES  = 2;
  localparam int CYC_BUDGET   = 400;

  logic        clkin1 = 1'b0;
  logic        rst    = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_relock = 1'b0;
  logic [4:0]  cmd_addr  = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        apb_sel, apb_en, apb_write;
  logic [4:0]  apb_addr;
  logic [15:0] apb_wdata;
  logic [15:0] apb_rdata = '0;
  logic        apb_ready = 1'b0;
  logic        pll_rst, lock = 1'b1, lock_sync, lock_lost;

  int n_vec = 0;
  int n_err = 0;

  always #5 clkin1 = ~clkin1;

  pll_apb_cfg_master #(
    .APB_TIMEOUT (APB_TIMEOUT),
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clkin1      (clkin1),
    .rst         (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_relock_i(cmd_relock),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .apb_sel_o   (apb_sel),
    .apb_en_o    (apb_en),
    .apb_write_o (apb_write),
    .apb_addr_o  (apb_addr),
    .apb_wdata_o (apb_wdata),
    .apb_rdata_i (apb_rdata),
    .apb_ready_i (apb_ready),
    .pll_rst_o   (pll_rst),
    .lock_i      (lock),
    .lock_sync_o (lock_sync),
    .lock_lost_o (lock_lost)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command from an IDLE negedge to the negedge after its response.
  // waits < 0: apb_ready never rises. lock_dly < 0: lock never returns after relock.
  task automatic run_cmd(input bit wr, input logic [4:0] addr, input logic [15:0] wdata,
                         input bit relock, input int waits, input int lock_dly,
                         input logic [15:0] rd_val, input string tag);
    int          exp_access, exp_rsp, exp_pll;
    logic [15:0] exp_rdata;
    logic [1:0]  exp_err;
    int          first_sel = -1, setup_n = 0, access_n = 0, pll_n = 0, rsp_cyc = -1, lw_k = -1;
    bit          apb_ok = 1'b1, busy_ok = 1'b1, ll_ok = 1'b1, pll_seen = 1'b0;
    logic [15:0] obs_rdata = '0;
    logic [1:0]  obs_err = '0;

    // Reference timing: SETUP in cycle 1, ACCESS from cycle 2, RESP right after.
    if (waits < 0) begin
      exp_access = APB_TIMEOUT;
      exp_rsp    = APB_TIMEOUT + 2;
      exp_pll    = 0;
      exp_rdata  = 16'h0000;
      exp_err    = 2'd1;
    end else begin
      exp_access = waits + 1;
      exp_rsp    = 3 + waits;
      exp_pll    = 0;
      exp_rdata  = wr ? 16'h0000 : rd_val;
      exp_err    = 2'd0;
      if (wr && relock) begin
        exp_pll = RST_CYCLES;
        if (lock_dly < 0 || lock_dly + SYNC_STAGES + 1 > LOCK_TIMEOUT) begin
          exp_rsp += RST_CYCLES + LOCK_TIMEOUT;
          exp_err  = 2'd2;
        end else begin
          exp_rsp += RST_CYCLES + lock_dly + SYNC_STAGES + 1;
        end
      end
    end

    check({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_addr   = addr;
    cmd_wdata  = wdata;
    cmd_relock = relock;
    apb_ready  = 1'b0;

    for (int cyc = 1; cyc <= CYC_BUDGET && rsp_cyc < 0; cyc++) begin
      @(negedge clkin1);
      if (cyc == 1) begin
        // Junk request while busy: must be ignored.
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_write  = 1'($urandom);
        cmd_addr   = 5'($urandom);
        cmd_wdata  = 16'($urandom);
        cmd_relock = 1'($urandom);
      end
      if (cmd_ready) busy_ok = 1'b0;
      if (lock_lost) ll_ok = 1'b0;
      if (apb_en && !apb_sel) apb_ok = 1'b0;
      if (apb_sel) begin
        if (first_sel < 0) first_sel = cyc;
        if (apb_addr !== addr || apb_write !== wr || apb_wdata !== (wr ? wdata : 16'h0000))
          apb_ok = 1'b0;
        if (!apb_en) begin
          setup_n++;
        end else begin
          if (waits >= 0 && access_n == waits) begin
            apb_ready = 1'b1;
            apb_rdata = rd_val;
          end else begin
            apb_ready = 1'b0;
            apb_rdata = 16'($urandom);
          end
          access_n++;
        end
      end else begin
        apb_ready = 1'b0;
      end
      if (rsp_valid) begin
        rsp_cyc   = cyc;
        obs_rdata = rsp_rdata;
        obs_err   = rsp_err;
        cmd_valid = 1'b0;
      end else if (pll_rst) begin
        pll_n++;
        pll_seen = 1'b1;
        lock     = 1'b0;
      end else if (pll_seen) begin
        lw_k++;
        if (lock_dly >= 0 && lw_k == lock_dly) lock = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    apb_ready = 1'b0;

    check({tag, "_rsp_seen"},   32'(rsp_cyc >= 0), 32'd1);
    check({tag, "_rsp_cycle"},  32'(rsp_cyc),      32'(exp_rsp));
    check({tag, "_sel_cycle"},  32'(first_sel),    32'd1);
    check({tag, "_setup_n"},    32'(setup_n),      32'd1);
    check({tag, "_access_n"},   32'(access_n),     32'(exp_access));
    check({tag, "_apb_stable"}, 32'(apb_ok),       32'd1);
    check({tag, "_busy_ready"}, 32'(busy_ok),      32'd1);
    check({tag, "_pll_rst_n"},  32'(pll_n),        32'(exp_pll));
    check({tag, "_no_lost"},    32'(ll_ok),        32'd1);
    check({tag, "_rdata"},      32'(obs_rdata),    32'(exp_rdata));
    check({tag, "_err"},        32'(obs_err),      32'(exp_err));

    @(negedge clkin1);
    check({tag, "_rsp_1cyc"},   32'(rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    check({tag, "_rdata_hold"}, 32'(rsp_rdata), 32'(exp_rdata));
    check({tag, "_err_hold"},   32'(rsp_err),   32'(exp_err));

    if (!lock) begin
      lock = 1'b1;
      repeat (SYNC_STAGES + 1) @(negedge clkin1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clkin1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_pll_rst",   32'(pll_rst),   32'd1);
    check("rst_apb_sel",   32'(apb_sel),   32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_lock_sync", 32'(lock_sync), 32'd0);
    check("rst_apb_addr",  32'(apb_addr),  32'd0);
    rst = 1'b0;
    @(negedge clkin1);
    check("rel_pll_rst",   32'(pll_rst),   32'd0);
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (SYNC_STAGES + 1) @(negedge clkin1);
    check("rel_lock_sync", 32'(lock_sync), 32'd1);
    check("rel_lock_lost", 32'(lock_lost), 32'd0);

    // Directed scenarios
    run_cmd(1'b0, 5'h03, 16'h0000, 1'b0,  0,  0, 16'hA5C3, "t1_read");
    run_cmd(1'b1, 5'h1F, 16'h1234, 1'b0,  3,  0, 16'hBEEF, "t2_write_ws3");
    run_cmd(1'b0, 5'h0A, 16'h0000, 1'b0, -1,  0, 16'h5555, "t3_apb_tmo");
    run_cmd(1'b1, 5'h02, 16'h00F0, 1'b1,  0, 40, 16'h0000, "t4_relock");
    run_cmd(1'b1, 5'h04, 16'h0F0F, 1'b1,  1, -1, 16'h0000, "t4_lock_tmo");

    // Reset during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h11; cmd_relock = 1'b0;
    @(negedge clkin1);
    cmd_valid = 1'b0;
    @(negedge clkin1);
    check("t5_in_access", 32'(apb_en), 32'd1);
    rst = 1'b1;
    @(negedge clkin1);
    check("t5_sel",       32'(apb_sel),   32'd0);
    check("t5_en",        32'(apb_en),    32'd0);
    check("t5_pll_rst",   32'(pll_rst),   32'd1);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clkin1);
    check("t5_rsp_valid2", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clkin1);
    check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5_pll_low",   32'(pll_rst),   32'd0);
    repeat (SYNC_STAGES + 1) @(negedge clkin1);
    run_cmd(1'b0, 5'h15, 16'h0000, 1'b0, 2, 0, 16'h3C3C, "t5_after");

    // Lock loss while IDLE: one pulse, SYNC_STAGES+1 edges after the drop
    lock = 1'b0;
    for (int i = 1; i <= SYNC_STAGES + 3; i++) begin
      @(negedge clkin1);
      check($sformatf("t6_lost_e%0d", i), 32'(lock_lost), 32'(i == SYNC_STAGES + 1));
    end
    lock = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clkin1);

    // Random commands
    for (int n = 0; n < 30; n++) begin
      bit          wr     = 1'($urandom);
      bit          relock = 1'($urandom_range(0, 3) == 0);
      int          waits  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      int          dly    = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 50));
      int          gap    = int'($urandom_range(0, 2));
      run_cmd(wr, 5'($urandom), 16'($urandom), relock, waits, dly, 16'($urandom),
              $sformatf("rnd%0d", n));
      repeat (gap) @(negedge clkin1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
